// File: rtl/bb_bus_pkg.sv
// Shared definitions for the bit-serial system bus: field widths, mode encoding and
// the slave endpoint state encoding.
package bb_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 8;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    typedef logic [2:0] slave_state_t;

    localparam slave_state_t S_IDLE  = 3'd0;
    localparam slave_state_t S_ADDR  = 3'd1;
    localparam slave_state_t S_WDATA = 3'd2;
    localparam slave_state_t S_WRITE = 3'd3;
    localparam slave_state_t S_RREQ  = 3'd4;
    localparam slave_state_t S_RWAIT = 3'd5;
    localparam slave_state_t S_SPLIT = 3'd6;
    localparam slave_state_t S_RDATA = 3'd7;

endpackage

// File: rtl/bb_serial_shifter.sv
// MSB-first shift register with a wrapping bit counter; done pulses combinationally
// on the shift that completes a full word.
module bb_serial_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;

    assign done = shift_en && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= load_data;
            cnt  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            data <= {data[WIDTH-2:0], bit_in};
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bb_slave_port.sv
// Bit-serial bus slave: collects address/write data, issues one-cycle local memory
// strobes, returns read data serially and splits the bus on slow reads.
module bb_slave_port
    import bb_bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned SPLIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sel,
    input  logic              mode,
    input  logic              wr_bus,
    input  logic              master_valid,
    output logic              slave_ready,
    output logic              rd_bus,
    output logic              slave_valid,
    input  logic              master_ready,
    output logic              split,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid
);

    localparam int unsigned WAIT_W = $clog2(SPLIT_CYCLES) + 1;

    slave_state_t          state, state_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [BUS_ADDR_W-1:0] addr_sh, addr_next;
    logic [BUS_DATA_W-1:0] rd_sh;
    logic                  addr_hs, wdata_hs, rdata_hs;
    logic                  addr_done, wdata_done, rdata_done;
    logic                  rd_load, in_idle;
    logic                  unused_bits;

    assign in_idle     = (state == S_IDLE);
    assign slave_ready = (state == S_ADDR) || (state == S_WDATA);
    assign slave_valid = (state == S_RDATA);
    assign rd_bus      = slave_valid & rd_sh[BUS_DATA_W-1];
    assign split       = (state == S_SPLIT);
    assign mem_we      = (state == S_WRITE);
    assign mem_re      = (state == S_RREQ);

    // sel gates every handshake so a simultaneous abort discards the bit.
    assign addr_hs  = sel && master_valid && (state == S_ADDR);
    assign wdata_hs = sel && master_valid && (state == S_WDATA);
    assign rdata_hs = sel && master_ready && slave_valid;
    assign rd_load  = mem_rvalid && (((state == S_RWAIT) && sel) || (state == S_SPLIT));

    assign addr_next   = {addr_sh[BUS_ADDR_W-2:0], wr_bus};
    assign unused_bits = ^{addr_sh, addr_next, rd_sh};

    bb_serial_shifter #(.WIDTH(BUS_ADDR_W)) u_addr_in (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (in_idle),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (addr_hs),
        .bit_in    (wr_bus),
        .data      (addr_sh),
        .done      (addr_done)
    );

    bb_serial_shifter #(.WIDTH(BUS_DATA_W)) u_data_in (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (in_idle),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (wdata_hs),
        .bit_in    (wr_bus),
        .data      (mem_wdata),
        .done      (wdata_done)
    );

    bb_serial_shifter #(.WIDTH(BUS_DATA_W)) u_data_out (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (in_idle),
        .load      (rd_load),
        .load_data (mem_rdata),
        .shift_en  (rdata_hs),
        .bit_in    (1'b0),
        .data      (rd_sh),
        .done      (rdata_done)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (sel && master_valid) state_next = S_ADDR;
            S_ADDR: begin
                if (!sel) state_next = S_IDLE;
                else if (addr_done) state_next = (mode == MODE_WRITE) ? S_WDATA : S_RREQ;
            end
            S_WDATA: begin
                if (!sel) state_next = S_IDLE;
                else if (wdata_done) state_next = S_WRITE;
            end
            S_WRITE: state_next = S_IDLE;
            S_RREQ:  state_next = sel ? S_RWAIT : S_IDLE;
            S_RWAIT: begin
                if (!sel) state_next = S_IDLE;
                else if (mem_rvalid) state_next = S_RDATA;
                else if (wait_cnt == WAIT_W'(SPLIT_CYCLES - 1)) state_next = S_SPLIT;
            end
            // Bus is released here, so sel no longer matters.
            S_SPLIT: if (mem_rvalid) state_next = S_RDATA;
            S_RDATA: if (!sel || rdata_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            mem_addr <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state == S_RWAIT) ? wait_cnt + 1'b1 : '0;
            if (addr_done) mem_addr <= addr_next[ADDR_W-1:0];
        end
    end

endmodule

// File: tb/tb_bb_slave_port.sv
// Directed and randomized bench for bb_slave_port against a transaction-level model.
module tb_bb_slave_port;

    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned SPLIT_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              sel = 1'b0;
    logic              mode = 1'b0;
    logic              wr_bus = 1'b0;
    logic              master_valid = 1'b0;
    logic              master_ready = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [7:0]        mem_rdata = 8'h00;
    logic              slave_ready, rd_bus, slave_valid, split, mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int split_cnt = 0;

    bb_slave_port #(.ADDR_W(ADDR_W), .SPLIT_CYCLES(SPLIT_CYCLES)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sel          (sel),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rd_bus       (rd_bus),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .split        (split),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        we_cnt    <= we_cnt + int'(mem_we);
        re_cnt    <= re_cnt + int'(mem_re);
        split_cnt <= split_cnt + int'(split);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] local_addr(input logic [15:0] a);
        return 32'(a) % (32'd1 << ADDR_W);
    endfunction

    // Presents n bits MSB-first, holding each until the slave accepts it.
    task automatic send_bits(input logic [15:0] val, input int n, input bit bp,
                             output int first_cyc);
        int i;
        int guard;
        bit gap;
        i = 0;
        guard = 0;
        gap = 1'b0;
        first_cyc = -1;
        while (i < n && guard < 200) begin
            guard++;
            if (bp && gap) begin
                master_valid = 1'b0;
            end else begin
                master_valid = 1'b1;
                wr_bus = val[n-1-i];
                if (slave_ready) begin
                    if (i == 0) first_cyc = cyc;
                    i++;
                end
            end
            gap = ~gap;
            tick();
        end
        master_valid = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL send_bits timeout: observed %0d bits accepted, expected %0d", i, n);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input bit bp);
        int c0, c1, we0;
        we0 = we_cnt;
        sel = 1'b1;
        mode = 1'b1;
        send_bits(addr, 16, bp, c0);
        send_bits({8'h00, data}, 8, bp, c1);
        check("wr mem_we", 32'(mem_we), 32'd1);
        check("wr mem_addr", 32'(mem_addr), local_addr(addr));
        check("wr mem_wdata", 32'(mem_wdata), 32'(data));
        if (!bp) check("wr latency", 32'(cyc - c0), 32'd24);
        tick();
        check("wr mem_we single", 32'(mem_we), 32'd0);
        check("wr we pulses", 32'(we_cnt - we0), 32'd1);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] rdata, input int k,
                           input bit bp_in, input bit bp_out, input bit drop_sel);
        int c0, re0, sp0, we0, got, guard;
        bit rtog;
        re0 = re_cnt;
        sp0 = split_cnt;
        we0 = we_cnt;
        got = 0;
        guard = 0;
        rtog = 1'b0;
        sel = 1'b1;
        mode = 1'b0;
        send_bits(addr, 16, bp_in, c0);
        check("rd mem_re", 32'(mem_re), 32'd1);
        check("rd mem_addr", 32'(mem_addr), local_addr(addr));
        for (int j = 1; j <= k; j++) begin
            tick();
            check("rd split window", 32'(split), 32'(j > int'(SPLIT_CYCLES)));
            if (drop_sel && j > int'(SPLIT_CYCLES)) sel = 1'b0;
            if (j == k) begin
                mem_rvalid = 1'b1;
                mem_rdata = rdata;
                sel = 1'b1;
            end
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata = 8'($urandom);
        check("rd split cleared", 32'(split), 32'd0);
        check("rd first valid", 32'(slave_valid), 32'd1);
        while (got < 8 && guard < 100) begin
            guard++;
            master_ready = bp_out ? rtog : 1'b1;
            rtog = ~rtog;
            if (slave_valid && master_ready) begin
                check("rd_bus bit", 32'(rd_bus), 32'(rdata[7-got]));
                got++;
            end
            tick();
        end
        master_ready = 1'b0;
        if (got < 8) begin
            checks++;
            errors++;
            $display("FAIL rd timeout: observed %0d bits returned, expected 8", got);
        end
        check("rd back to idle", 32'(slave_valid), 32'd0);
        check("rd re pulses", 32'(re_cnt - re0), 32'd1);
        check("rd no we", 32'(we_cnt - we0), 32'd0);
        check("rd split cycles", 32'(split_cnt - sp0),
              32'((k > int'(SPLIT_CYCLES)) ? k - int'(SPLIT_CYCLES) : 0));
    endtask

    initial begin
        int c0, we0, re0, k;
        logic [15:0] ra;
        logic [7:0]  rd;

        // Reset state
        #2;
        check("rst slave_ready", 32'(slave_ready), 32'd0);
        check("rst slave_valid", 32'(slave_valid), 32'd0);
        check("rst split", 32'(split), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst strobes", 32'({mem_we, mem_re, rd_bus}), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Directed plan
        do_write(16'hA5C3, 8'h5A, 1'b0);
        do_read(16'h0012, 8'hC6, 1, 1'b0, 1'b0, 1'b0);
        do_read(16'h0BEE, 8'h93, 10, 1'b0, 1'b0, 1'b1);
        do_read(16'h4321, 8'h6D, SPLIT_CYCLES, 1'b0, 1'b0, 1'b0);
        do_write(16'hA5C3, 8'h5A, 1'b1);
        do_read(16'h0012, 8'hC6, 1, 1'b1, 1'b1, 1'b0);

        // Abort after five address bits
        we0 = we_cnt;
        re0 = re_cnt;
        sel = 1'b1;
        mode = 1'b1;
        send_bits(16'hFFFF, 5, 1'b0, c0);
        sel = 1'b0;
        master_valid = 1'b1;
        wr_bus = 1'b1;
        tick();
        check("abort idle", 32'(slave_ready), 32'd0);
        master_valid = 1'b0;
        sel = 1'b1;
        tick();
        check("abort stays idle", 32'(slave_ready), 32'd0);
        check("abort no strobes", 32'((we_cnt - we0) + (re_cnt - re0)), 32'd0);
        do_write(16'h1357, 8'hE4, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            ra = 16'($urandom);
            rd = 8'($urandom);
            k = int'($urandom_range(1, 10));
            if ($urandom_range(0, 1) == 1)
                do_write(ra, rd, 1'($urandom));
            else
                do_read(ra, rd, k, 1'($urandom), 1'($urandom),
                        (k > int'(SPLIT_CYCLES)) && ($urandom_range(0, 1) == 1));
        end

        // Reset during SPLIT
        sel = 1'b1;
        mode = 1'b0;
        send_bits(16'h0777, 16, 1'b0, c0);
        for (int j = 1; j <= int'(SPLIT_CYCLES) + 1; j++) tick();
        check("pre-reset split", 32'(split), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async rst split", 32'(split), 32'd0);
        check("async rst mem_addr", 32'(mem_addr), 32'd0);
        check("async rst outputs",
              32'({slave_ready, slave_valid, rd_bus, mem_we, mem_re, mem_wdata}), 32'd0);
        tick();
        rstn = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 8'hFF;
        tick();
        mem_rvalid = 1'b0;
        check("late rvalid ignored", 32'(slave_valid), 32'd0);
        tick();
        check("late rvalid no split", 32'({split, slave_valid}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
